mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Control unit for the multicycle ARMv4 core; sits directly upstream of the datapath and drives every datapath select and enable.
- Decodes the latched instruction, sequences a main FSM, and evaluates ARM condition codes against an internal NZCV flags register.
- Gates architectural writes (PC, register file, memory) with the condition result.
- Supported instructions:
  - data-processing (register or immediate operand2): AND, EOR, SUB, ADD, ORR, CMP
  - LDR/STR with immediate offset
  - B

Parameters:
STATE_W, 4, width of state encoding and of the State debug port.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high.
Instr  in  20  bits [31:12] of the latched instruction register (cond, op, funct, Rn, Rd).
ALUFlags  in  4  combinational {N,Z,C,V} from the datapath ALU.
PCWrite  out  1  PC register load enable.
MemWrite  out  1  data memory write strobe.
RegWrite  out  1  register file write enable.
IRWrite  out  1  instruction register load enable.
AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
RegSrc  out  2  bit0: RA1=R15; bit1: RA2=Rd. Write-address select uses the full value; 00 = Rd.
ALUSrcA  out  2  0=A register, 1=PC, 2=zero.
ALUSrcB  out  2  0=RD2, 1=ExtImm, 2=constant 4.
ResultSrc  out  2  0=ALUOut, 1=memory data, 2=PC+4.
ImmSrc  out  2  0=8-bit DP immediate, 1=12-bit memory offset, 2=24-bit branch offset <<2 sign-extended.
ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR.
State  out  STATE_W  current FSM state (debug/verification only).

Behaviour:
Clocking and reset:
- Single clock domain: clk.
- Reset is synchronous, active-high.
- Reset effects: state <= FETCH and flags NZCV <= 0000.
- While reset=1, PCWrite, MemWrite, RegWrite and IRWrite are forced 0, and all selects are 0.
- Reset asserted mid-instruction aborts it; no partial write occurs in that cycle.

Output decoding:
- All outputs are decoded combinationally from state, Instr and CondEx.
- Instr is stable from DECODE until the next FETCH.

Condition evaluation:
- CondEx is evaluated from Instr[31:28] and the flags register.
- All 15 ARM condition codes are supported.
- Code 1111 evaluates as false.

FSM states and their outputs (unlisted signals are 0):
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=2, ResultSrc=2, PCWrite=1. Next state: DECODE.
- DECODE: RegSrc=10 if STR, otherwise 00. ALUSrcA=1, ALUSrcB=2, ADD.
  - op=00 with I=1 goes to EXECI.
  - op=00 with I=0 goes to EXECR.
  - op=01 goes to MEMADR.
  - op=10 goes to BRANCH.
  - op=11 goes to FETCH (treated as NOP).
- EXECR: ALUSrcA=0, ALUSrcB=0, ALUControl from cmd. Next state: ALUWB.
- EXECI: as EXECR, but ALUSrcB=1 and ImmSrc=0. Next state: ALUWB.
- ALUWB: ResultSrc=0, RegWrite=CondEx & ~CMP & supported. Next state: FETCH.
- MEMADR: ALUSrcA=0, ALUSrcB=1, ImmSrc=1, ALUControl = ADD if U=1, SUB if U=0.
  - L=1 goes to MEMRD; L=0 goes to MEMWR.
- MEMRD: AdrSrc=1. Next state: MEMWB.
- MEMWB: AdrSrc=1, ResultSrc=1, RegWrite=CondEx. Next state: FETCH.
- MEMWR: AdrSrc=1, RegSrc=10, MemWrite=CondEx. Next state: FETCH.
- BRANCH: RegSrc=01, ALUSrcA=1, ALUSrcB=1, ImmSrc=2, ADD. Next state: BRWB.
- BRWB: ResultSrc=0, PCWrite=CondEx. Next state: FETCH.

Decode of cmd (Instr[24:21]):
- 0000 → AND
- 0001 → EOR
- 0010 → SUB
- 0100 → ADD
- 1100 → ORR
- 1010 → CMP (SUB, no register write, flags always updated)
- Any other cmd is unsupported: no register write, no flag update.

Flag update:
- Flags are captured at the end of EXECR/EXECI when CondEx & (S | CMP) & supported.
- N and Z are always loaded.
- C and V are loaded only for ADD/SUB/CMP; otherwise they hold.

Latency in cycles:
- Data-processing: 4.
- STR: 4.
- LDR: 5.
- B: 4.
- op=11 (NOP): 2.
- Instructions that fail their condition take the same cycle count, with their writes suppressed.

Branch target:
- Target = (instruction address + 4) + ExtImm.
- This is the core's fixed branch-offset convention.

Decomposition:
Shared package mc_ctrl_pkg holds:
- FSM state encodings
- ALUControl codes
- op codes
- cmd codes
- ARM condition codes
- select encodings (AdrSrc, ALUSrcA/B, ResultSrc, ImmSrc, RegSrc)

Sub-module cond_unit contains:
- the NZCV flags register
- the 15-code condition evaluator, producing CondEx
- the flag-update write-mask logic

mc_controller contains the FSM and instruction decode.

Test Plan:
- Reset held 3 cycles, then released → State=FETCH; IRWrite=1, PCWrite=1, ResultSrc=2 in the first post-reset cycle; no write strobes while reset=1.
- ADDS with ALUFlags=0100 during EXECI → FSM path FETCH, DECODE, EXECI, ALUWB; ALUControl=000, RegWrite=1 in ALUWB; flags become Z=1.
- CMP sets Z=1, then BEQ → BRWB has PCWrite=1; repeat the sequence with BNE → PCWrite=0 in BRWB and the FSM still returns to FETCH.
- LDR with U=0 → MEMADR ALUControl=001; MEMWB has ResultSrc=1, RegWrite=1; total 5 cycles. STR → MemWrite=1 only in MEMWR, RegSrc=10; total 4 cycles.
- Unsupported cmd=1101 with S=1 → no RegWrite, flags unchanged. op=11 → DECODE goes to FETCH; 2 cycles total.
- Assert reset during MEMWR → MemWrite=0 in that cycle; State=FETCH on the next cycle; flags=0000.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle ARMv4 control unit: FSM states,
// instruction field codes, datapath select encodings and the cmd decoder.
package mc_ctrl_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_BRWB   = 4'd10
  } state_t;

  // ALUControl codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  // op field, Instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  // cmd field, Instr[24:21]
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // ARM condition codes, Instr[31:28]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Datapath select encodings
  localparam logic       ADR_PC      = 1'b0;
  localparam logic       ADR_ALUOUT  = 1'b1;
  localparam logic [1:0] SRCA_REG    = 2'd0;
  localparam logic [1:0] SRCA_PC     = 2'd1;
  localparam logic [1:0] SRCA_ZERO   = 2'd2;
  localparam logic [1:0] SRCB_RD2    = 2'd0;
  localparam logic [1:0] SRCB_IMM    = 2'd1;
  localparam logic [1:0] SRCB_FOUR   = 2'd2;
  localparam logic [1:0] RES_ALUOUT  = 2'd0;
  localparam logic [1:0] RES_MEM     = 2'd1;
  localparam logic [1:0] RES_PC4     = 2'd2;
  localparam logic [1:0] IMM_DP      = 2'd0;
  localparam logic [1:0] IMM_MEM     = 2'd1;
  localparam logic [1:0] IMM_BR      = 2'd2;
  localparam logic [1:0] REGSRC_RD   = 2'b00;
  localparam logic [1:0] REGSRC_PC   = 2'b01;
  localparam logic [1:0] REGSRC_RD2  = 2'b10;

  typedef struct packed {
    logic       supported;  // cmd is one the core implements
    logic       is_cmp;     // compare: flags only, no register write
    logic       is_arith;   // ADD/SUB/CMP: C and V are meaningful
    logic [2:0] alu;        // ALUControl for this cmd
  } cmd_info_t;

  // Unsupported cmds still drive ADD on the ALU; their result is never
  // written and their flags are never captured.
  function automatic cmd_info_t cmd_decode(input logic [3:0] cmd);
    cmd_info_t ci;
    ci = '{supported: 1'b1, is_cmp: 1'b0, is_arith: 1'b0, alu: ALU_ADD};
    case (cmd)
      CMD_AND: ci.alu = ALU_AND;
      CMD_EOR: ci.alu = ALU_EOR;
      CMD_ORR: ci.alu = ALU_ORR;
      CMD_ADD: begin ci.alu = ALU_ADD; ci.is_arith = 1'b1; end
      CMD_SUB: begin ci.alu = ALU_SUB; ci.is_arith = 1'b1; end
      CMD_CMP: begin ci.alu = ALU_SUB; ci.is_arith = 1'b1; ci.is_cmp = 1'b1; end
      default: ci.supported = 1'b0;
    endcase
    return ci;
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control bundle between the control unit (master) and the datapath (slave).
// There is no handshake on this bundle: every signal is a level that is
// valid for the whole clock cycle it is driven in, and the datapath acts on
// the enables at the next rising edge.
interface mc_controller_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        MemWrite;
  logic        RegWrite;
  logic        IRWrite;
  logic        AdrSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [2:0]  ALUControl;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );
endinterface

// File: rtl/mc_controller_cond_unit.sv
// NZCV flags register, ARM condition evaluator and flag write masking.
module cond_unit
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,   // {N,Z,C,V} from the ALU this cycle
  input  logic       exec_cycle,  // FSM is in EXECR or EXECI
  input  logic       s_bit,
  input  logic       is_cmp,
  input  logic       is_arith,
  input  logic       supported,
  output logic       cond_ex
);

  logic [3:0] nzcv_q;
  logic       n, z, c, v;
  logic       nz_we, cv_we;

  assign {n, z, c, v} = nzcv_q;

  // Evaluate the condition field against the stored flags; 1111 never passes.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // N/Z follow any flag-setting op; C/V only when the ALU did arithmetic.
  assign nz_we = exec_cycle & cond_ex & (s_bit | is_cmp) & supported;
  assign cv_we = nz_we & is_arith;

  // Flags register with per-pair write enables.
  always_ff @(posedge clk) begin
    if (reset) begin
      nzcv_q <= 4'b0000;
    end else begin
      if (nz_we) nzcv_q[3:2] <= alu_flags[3:2];
      if (cv_we) nzcv_q[1:0] <= alu_flags[1:0];
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARMv4 control unit: instruction decode, main FSM and the
// condition-gated write enables for PC, register file and memory.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  mc_controller_if.master    bus,
  output logic [STATE_W-1:0] State
);

  state_t    state_q, state_d;
  cmd_info_t ci;
  logic      cond_ex;
  logic [3:0] cond;
  logic [1:0] op;
  logic [3:0] cmd;
  logic       i_bit, s_bit, l_bit, u_bit;
  logic       unused_bits;

  // Instr holds bits [31:12]; the Rn/Rd fields only matter to the datapath.
  assign cond        = bus.Instr[19:16];
  assign op          = bus.Instr[15:14];
  assign i_bit       = bus.Instr[13];
  assign cmd         = bus.Instr[12:9];
  assign u_bit       = bus.Instr[11];
  assign s_bit       = bus.Instr[8];
  assign l_bit       = bus.Instr[8];
  assign unused_bits = ^bus.Instr[7:0];
  assign ci          = cmd_decode(cmd);

  assign State = STATE_W'(state_q);

  cond_unit u_cond (
    .clk        (clk),
    .reset      (reset),
    .cond       (cond),
    .alu_flags  (bus.ALUFlags),
    .exec_cycle ((state_q == S_EXECR) || (state_q == S_EXECI)),
    .s_bit      (s_bit),
    .is_cmp     (ci.is_cmp),
    .is_arith   (ci.is_arith),
    .supported  (ci.supported),
    .cond_ex    (cond_ex)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next state and per-state datapath controls; reset zeroes every control.
  always_comb begin
    state_d        = state_q;
    bus.PCWrite    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.AdrSrc     = ADR_PC;
    bus.RegSrc     = REGSRC_RD;
    bus.ALUSrcA    = SRCA_REG;
    bus.ALUSrcB    = SRCB_RD2;
    bus.ResultSrc  = RES_ALUOUT;
    bus.ImmSrc     = IMM_DP;
    bus.ALUControl = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.PCWrite   = 1'b1;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_PC4;
        state_d       = S_DECODE;
      end
      S_DECODE: begin
        bus.RegSrc  = (op == OP_MEM && !l_bit) ? REGSRC_RD2 : REGSRC_RD;
        bus.ALUSrcA = SRCA_PC;
        bus.ALUSrcB = SRCB_FOUR;
        case (op)
          OP_DP:   state_d = i_bit ? S_EXECI : S_EXECR;
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_EXECR: begin
        bus.ALUControl = ci.alu;
        state_d        = S_ALUWB;
      end
      S_EXECI: begin
        bus.ALUSrcB    = SRCB_IMM;
        bus.ImmSrc     = IMM_DP;
        bus.ALUControl = ci.alu;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegWrite = cond_ex & ~ci.is_cmp & ci.supported;
        state_d      = S_FETCH;
      end
      S_MEMADR: begin
        bus.ALUSrcB    = SRCB_IMM;
        bus.ImmSrc     = IMM_MEM;
        bus.ALUControl = u_bit ? ALU_ADD : ALU_SUB;
        state_d        = l_bit ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.AdrSrc = ADR_ALUOUT;
        state_d    = S_MEMWB;
      end
      S_MEMWB: begin
        bus.AdrSrc    = ADR_ALUOUT;
        bus.ResultSrc = RES_MEM;
        bus.RegWrite  = cond_ex;
        state_d       = S_FETCH;
      end
      S_MEMWR: begin
        bus.AdrSrc   = ADR_ALUOUT;
        bus.RegSrc   = REGSRC_RD2;
        bus.MemWrite = cond_ex;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        bus.RegSrc  = REGSRC_PC;
        bus.ALUSrcA = SRCA_PC;
        bus.ALUSrcB = SRCB_IMM;
        bus.ImmSrc  = IMM_BR;
        state_d     = S_BRWB;
      end
      S_BRWB: begin
        bus.PCWrite = cond_ex;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      state_d        = S_FETCH;
      bus.PCWrite    = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.IRWrite    = 1'b0;
      bus.AdrSrc     = ADR_PC;
      bus.RegSrc     = REGSRC_RD;
      bus.ALUSrcA    = SRCA_REG;
      bus.ALUSrcB    = SRCB_RD2;
      bus.ResultSrc  = RES_ALUOUT;
      bus.ImmSrc     = IMM_DP;
      bus.ALUControl = ALU_ADD;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle expected control vectors are
// queued with each instruction and compared at the falling edge.
module tb_mc_controller;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] state_dbg;
  int         total = 0;
  int         bad = 0;
  string      tag = "reset";
  logic [21:0] exp_q[$];

  mc_controller_if intf ();

  mc_controller #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf.master),
    .State (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // {State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
  //  ALUSrcB, ResultSrc, ImmSrc, ALUControl}
  function automatic logic [21:0] ev(input state_t s, input logic pc, mw, rw, ir, adr,
                                     input logic [1:0] rs, sa, sb, res, imm,
                                     input logic [2:0] alu);
    return {s, pc, mw, rw, ir, adr, rs, sa, sb, res, imm, alu};
  endfunction

  function automatic logic [21:0] obs();
    return {state_dbg, intf.PCWrite, intf.MemWrite, intf.RegWrite, intf.IRWrite,
            intf.AdrSrc, intf.RegSrc, intf.ALUSrcA, intf.ALUSrcB, intf.ResultSrc,
            intf.ImmSrc, intf.ALUControl};
  endfunction

  // instruction encoders (bits [31:12])
  function automatic logic [19:0] dp(input logic [3:0] c, input logic i,
                                     input logic [3:0] cmd, input logic s);
    return {c, 2'b00, i, cmd, s, 4'h1, 4'h2};
  endfunction
  function automatic logic [19:0] mem(input logic [3:0] c, input logic u, input logic l);
    return {c, 2'b01, 1'b0, 1'b1, u, 1'b0, 1'b0, l, 4'h3, 4'h4};
  endfunction
  function automatic logic [19:0] br(input logic [3:0] c);
    return {c, 4'b1010, 12'h010};
  endfunction

  // expected-sequence builders
  task automatic push_fetch();
    exp_q.push_back(ev(S_FETCH, 1, 0, 0, 1, 0, 2'b00, 2'd1, 2'd2, 2'd2, 2'd0, 3'b000));
  endtask
  task automatic push_decode(input logic [1:0] rs);
    exp_q.push_back(ev(S_DECODE, 0, 0, 0, 0, 0, rs, 2'd1, 2'd2, 2'd0, 2'd0, 3'b000));
  endtask
  task automatic exp_dp(input logic imm, input logic [2:0] alu, input logic rw);
    push_fetch();
    push_decode(2'b00);
    exp_q.push_back(ev(imm ? S_EXECI : S_EXECR, 0, 0, 0, 0, 0, 2'b00, 2'd0,
                       imm ? 2'd1 : 2'd0, 2'd0, 2'd0, alu));
    exp_q.push_back(ev(S_ALUWB, 0, 0, rw, 0, 0, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000));
  endtask
  task automatic push_memadr(input logic u);
    exp_q.push_back(ev(S_MEMADR, 0, 0, 0, 0, 0, 2'b00, 2'd0, 2'd1, 2'd0, 2'd1,
                       u ? 3'b000 : 3'b001));
  endtask
  task automatic exp_ldr(input logic u, input logic rw);
    push_fetch();
    push_decode(2'b00);
    push_memadr(u);
    exp_q.push_back(ev(S_MEMRD, 0, 0, 0, 0, 1, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000));
    exp_q.push_back(ev(S_MEMWB, 0, 0, rw, 0, 1, 2'b00, 2'd0, 2'd0, 2'd1, 2'd0, 3'b000));
  endtask
  task automatic exp_str(input logic u, input logic mw);
    push_fetch();
    push_decode(2'b10);
    push_memadr(u);
    exp_q.push_back(ev(S_MEMWR, 0, mw, 0, 0, 1, 2'b10, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000));
  endtask
  task automatic exp_br(input logic pc);
    push_fetch();
    push_decode(2'b00);
    exp_q.push_back(ev(S_BRANCH, 0, 0, 0, 0, 0, 2'b01, 2'd1, 2'd1, 2'd0, 2'd2, 3'b000));
    exp_q.push_back(ev(S_BRWB, pc, 0, 0, 0, 0, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000));
  endtask

  // scoreboard: compare one cycle at the falling edge, then advance
  task automatic check_cycle();
    logic [21:0] e, o;
    @(negedge clk);
    total++;
    o = obs();
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s no_expected observed=%h", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // driver: present an instruction and flags, then check n cycles
  task automatic run(input string t, input logic [19:0] ins, input logic [3:0] af,
                     input int n);
    tag = t;
    intf.Instr = ins;
    intf.ALUFlags = af;
    for (int k = 0; k < n; k++) check_cycle();
  endtask

  initial begin
    reset = 1'b1;
    intf.Instr = 20'h0;
    intf.ALUFlags = 4'h0;
    @(posedge clk);
    #1;
    // reset held: state FETCH, every control forced low
    for (int k = 0; k < 2; k++)
      exp_q.push_back(ev(S_FETCH, 0, 0, 0, 0, 0, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000));
    run("reset_hold", 20'h0, 4'h0, 2);
    reset = 1'b0;

    // ADDS imm, ALU reports Z -> flags 0100
    exp_dp(1'b1, 3'b000, 1'b1); run("adds_imm", dp(COND_AL, 1, CMD_ADD, 1), 4'b0100, 4);
    exp_br(1'b1);               run("beq_after_adds", br(COND_EQ), 4'h0, 4);
    // SUBS reg, ALU reports C -> flags 0010
    exp_dp(1'b0, 3'b001, 1'b1); run("subs_reg", dp(COND_AL, 0, CMD_SUB, 1), 4'b0010, 4);
    exp_br(1'b0);               run("beq_after_subs", br(COND_EQ), 4'h0, 4);
    // ANDS loads N,Z only: flags 1110
    exp_dp(1'b1, 3'b010, 1'b1); run("ands_imm", dp(COND_AL, 1, CMD_AND, 1), 4'b1111, 4);
    exp_br(1'b0);               run("bvs_after_ands", br(COND_VS), 4'h0, 4);
    exp_br(1'b1);               run("bcs_after_ands", br(COND_CS), 4'h0, 4);
    exp_br(1'b1);               run("bmi_after_ands", br(COND_MI), 4'h0, 4);
    // CMP loads all four: flags 0100
    exp_dp(1'b0, 3'b001, 1'b0); run("cmp_reg", dp(COND_AL, 0, CMD_CMP, 0), 4'b0100, 4);
    exp_br(1'b1);               run("beq_after_cmp", br(COND_EQ), 4'h0, 4);
    exp_br(1'b0);               run("bcs_after_cmp", br(COND_CS), 4'h0, 4);
    exp_br(1'b0);               run("bgt_after_cmp", br(COND_GT), 4'h0, 4);
    exp_br(1'b1);               run("ble_after_cmp", br(COND_LE), 4'h0, 4);
    exp_br(1'b1);               run("bls_after_cmp", br(COND_LS), 4'h0, 4);
    exp_dp(1'b0, 3'b001, 1'b0); run("cmp_again", dp(COND_AL, 0, CMD_CMP, 0), 4'b0100, 4);
    exp_br(1'b0);               run("bne_after_cmp", br(COND_NE), 4'h0, 4);

    // memory: LDR down (5 cycles), STR up (4 cycles)
    exp_ldr(1'b0, 1'b1);        run("ldr_u0", mem(COND_AL, 0, 1), 4'h0, 5);
    exp_str(1'b1, 1'b1);        run("str_u1", mem(COND_AL, 1, 0), 4'h0, 4);

    // unsupported cmd with S: no write, flags (Z=1) kept
    exp_dp(1'b0, 3'b000, 1'b0); run("unsup_1101", dp(COND_AL, 0, 4'b1101, 1), 4'b0000, 4);
    exp_br(1'b1);               run("beq_after_unsup", br(COND_EQ), 4'h0, 4);
    // logic ops without S leave flags alone
    exp_dp(1'b1, 3'b100, 1'b1); run("eor_imm", dp(COND_AL, 1, CMD_EOR, 0), 4'b0000, 4);
    exp_dp(1'b0, 3'b011, 1'b1); run("orr_reg", dp(COND_AL, 0, CMD_ORR, 0), 4'b1000, 4);
    exp_br(1'b1);               run("beq_after_noS", br(COND_EQ), 4'h0, 4);
    // op=11 NOP: two cycles
    push_fetch(); push_decode(2'b00);
    run("nop", {COND_AL, 2'b11, 14'h0}, 4'h0, 2);

    // failing conditions (Z=1): same length, writes suppressed
    exp_dp(1'b1, 3'b000, 1'b0); run("adds_ne_fail", dp(COND_NE, 1, CMD_ADD, 1), 4'b0000, 4);
    exp_br(1'b1);               run("beq_after_fail", br(COND_EQ), 4'h0, 4);
    exp_ldr(1'b1, 1'b0);        run("ldr_ne_fail", mem(COND_NE, 1, 1), 4'h0, 5);
    exp_str(1'b0, 1'b0);        run("str_ne_fail", mem(COND_NE, 0, 0), 4'h0, 4);
    exp_br(1'b0);               run("b_nv", br(COND_NV), 4'h0, 4);
    exp_br(1'b1);               run("b_al", br(COND_AL), 4'h0, 4);

    // reset arriving in MEMWR: no store that cycle, back to FETCH, flags clear
    push_fetch(); push_decode(2'b10); push_memadr(1'b1);
    run("str_pre_reset", mem(COND_AL, 1, 0), 4'h0, 3);
    reset = 1'b1;
    exp_q.push_back(ev(S_MEMWR, 0, 0, 0, 0, 0, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000));
    run("reset_in_memwr", mem(COND_AL, 1, 0), 4'h0, 1);
    reset = 1'b0;
    exp_br(1'b0);               run("beq_after_reset", br(COND_EQ), 4'h0, 4);
    exp_br(1'b1);               run("bne_after_reset", br(COND_NE), 4'h0, 4);
    exp_br(1'b1);               run("bcc_after_reset", br(COND_CC), 4'h0, 4);

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL leftover_expected observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
